rr_arb_mux: RTL

Registered N-channel round-robin arbitrating multiplexer with valid/ready handshakes on every input and on the output. It generalises the fixed 2:1 and 4:1 selectors: width and channel count are parameters, and the select comes from a fair internal arbiter instead of an external `sel`. It sits in the datapath wherever several producers share one consumer, for example several operand sources feeding a single adder. It adds exactly one register stage and sustains one beat per cycle.

---
 rtl/rr_arb_mux_if.sv | 28 ++
 rtl/rr_arb_mux.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: per-channel valid/ready/data/last inputs and one registered output.
// The arbiter itself connects through the slave modport; producers/consumer use master.
interface rr_arb_mux_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_last;
  logic                      out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N-channel round-robin arbitrating mux, one beat per cycle, one cycle latency.
// Optional packet lock (hold the grant until in_last) is enabled by defining RR_ARB_MUX_LOCK_EN.
//
// Lock FSM (only with RR_ARB_MUX_LOCK_EN):
//   state     | meaning
//   st_open   | every valid channel competes round-robin from ptr
//   st_locked | only lock_ch is eligible until its in_last beat is accepted
module rr_arb_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] last_ch = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   n_ch    = (SEL_W + 1)'(CHANNELS);

  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    ptr_nxt;
  logic [SEL_W-1:0]    grant;
  logic [SEL_W:0]      idx;
  logic [CHANNELS-1:0] elig;
  logic                found;
  logic                any_valid;
  logic                load;
  logic                fire;
  logic                ptr_adv;

  assign load      = !bus.out_valid || bus.out_ready;
  assign any_valid = |elig;
  assign fire      = load && any_valid;

`ifdef RR_ARB_MUX_LOCK_EN
  typedef enum logic {st_open, st_locked} lock_st_t;

  lock_st_t         state;
  lock_st_t         state_nxt;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] lock_ch_nxt;
  logic             lock;

  assign lock = (state == st_locked);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= st_open;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  always_comb begin
    elig = bus.in_valid;
    if (lock) elig = bus.in_valid & (CHANNELS'(1) << lock_ch);
  end

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    case (state)
      st_open: begin
        if (fire && !bus.in_last[grant]) begin
          state_nxt   = st_locked;
          lock_ch_nxt = grant;
        end
      end
      st_locked: begin
        if (fire && bus.in_last[grant]) state_nxt = st_open;
      end
      default: state_nxt = st_open;
    endcase
  end

  // while locked the pointer freezes; the releasing beat moves it past lock_ch
  assign ptr_adv = !lock || bus.in_last[grant];
`else
  assign elig    = bus.in_valid;
  assign ptr_adv = 1'b1;
`endif

  // circular search from ptr; explicit wrap keeps non-power-of-two channel counts correct
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, ptr} + (SEL_W + 1)'(k);
      if (idx >= n_ch) idx = idx - n_ch;
      if (!found && elig[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        grant = idx[SEL_W-1:0];
      end
    end
  end

  assign ptr_nxt = (grant == last_ch) ? '0 : grant + SEL_W'(1);

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.in_ready[i] = !rst && fire && (grant == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_last  <= 1'b0;
      ptr           <= '0;
    end else if (load) begin
      if (any_valid) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.in_data[grant*WIDTH +: WIDTH];
        bus.out_sel   <= grant;
        bus.out_last  <= bus.in_last[grant];
        if (ptr_adv) ptr <= ptr_nxt;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
